pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor, the successor to the fixed 4-bit ripple-carry adder. It splits a WIDTH-bit operation into STAGES carry segments, each registered, so the carry ripples through one segment per cycle. It accepts one operation per cycle through a valid/ready handshake and supports add/subtract mode plus carry, borrow and signed-overflow flags. It sits between operand-producing logic and result consumers in the datapath.

## Interface
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES
- STAGES, 4, number of pipeline segments, 1..WIDTH; SEG = WIDTH/STAGES bits per segment
- clk_i  input  1  clock; all state updates on the rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- valid_i  input  1  operands valid
- ready_o  output  1  block accepts operands this cycle
- a_i  input  WIDTH  operand A (unsigned or two's complement)
- b_i  input  WIDTH  operand B
- cin_i  input  1  carry-in (add) / borrow-in (sub)
- sub_i  input  1  0: A+B+cin_i; 1: A−B−cin_i
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts result
- sum_o  output  WIDTH  result
- cout_o  output  1  carry-out; in sub mode 1 = no borrow
- ovf_o  output  1  signed overflow

## Operation
- Effective operand: b_eff = sub_i ? ~b_i : b_i. Effective carry-in: c0 = cin_i XOR sub_i.
- Stage k (0..STAGES−1) adds segment k of A and b_eff, bits [k·SEG +: SEG], plus the carry registered by stage k−1. Stage 0 uses c0.
- Stage k registers its SEG-bit partial sum, its carry-out, and a valid bit.
- Operand segments above k are carried forward unchanged; they are skewed registers.
- Completed sum segments below k are delayed so all segments reach the output together.
- Final result:
  - sum_o = (A + b_eff + c0) mod 2^WIDTH
  - cout_o = carry out of bit WIDTH−1
  - ovf_o = (A[MSB] == b_eff[MSB]) && (sum_o[MSB] != A[MSB])
- Stall is global: advance = !valid_o || ready_i.
  - On advance, every stage shifts one position, bubbles included.
  - Otherwise every register holds.
- ready_o = advance, combinational from ready_i and valid_o.
- Transfer in: valid_i && ready_o. Stage-0 valid loads valid_i && ready_o.
- Transfer out: valid_o && ready_i.
- valid_o, sum_o, cout_o and ovf_o come from the last stage registers.
- No internal FSM beyond the per-stage valid bits. Occupancy is 0..STAGES items.
- Bubbles are not compacted. An empty stage ahead of a stalled output still waits for advance.

## Timing
- Reset, asynchronous, while rst_n_i is low:
  - all valid bits = 0, so valid_o = 0
  - sum_o = 0, cout_o = 0, ovf_o = 0, all data registers = 0
  - ready_o = 1 (follows from valid_o = 0)
- Reset asserted mid-operation discards all in-flight items. No partial result appears after release.
- Latency: an operand accepted at edge n appears on valid_o/sum_o after edge n+STAGES−1, i.e. it is presented for STAGES cycles counting the accept cycle. With STAGES=1 the result is visible the cycle after acceptance.
- Throughput: one operation per cycle while ready_i = 1.
- Backpressure:
  - With valid_o = 1 and ready_i = 0, the outputs stay stable and ready_o = 0.
  - Accept and output transfer occur in the same cycle when ready_i = 1.
- Operands and sub_i are sampled only on accept. The inputs may change freely at other times.
- Critical path: one SEG-bit ripple plus the carry register.

## Test plan
- WIDTH=16, STAGES=4: a=0xFFFF, b=0x0001, cin=0, sub=0 → after 4 cycles sum_o=0x0000, cout_o=1, ovf_o=0. This checks the carry rippling through all segments.
- sub=1, a=0x8000, b=0x0001, cin=0 → sum_o=0x7FFF, cout_o=1, ovf_o=1. Then a=0x0000, b=0x0001 → sum_o=0xFFFF, cout_o=0 (borrow), ovf_o=0.
- Back-to-back stream of 0x0FFF+0x0001, 0x1234+0x4321, 0x7FFF+0x0001, one per cycle with ready_i=1:
  - results 0x1000, 0x5555, 0x8000 on consecutive cycles
  - ovf_o set only on 0x8000
- Backpressure:
  - Stream 6 items with ready_i=0 from cycle 5: ready_o drops once valid_o=1, and exactly 4 items are held with sum_o stable.
  - Release ready_i: all 6 items emerge in order, none lost or duplicated.
- Reset mid-stream with 3 items in flight: rst_n_i low for 1 cycle → valid_o=0 and outputs 0 immediately. No stale result follows release; a new item appears after 4 cycles.
- Degenerate STAGES=1, WIDTH=8: a=0x7F, b=0x01 → next cycle sum_o=0x80, ovf_o=1. Random add/sub regression versus a reference model for STAGES ∈ {1,2,4,8}.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES carry
// segments, one segment resolved per cycle, with a global valid/ready stall.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int SEG = WIDTH / STAGES;

  logic             advance;

  // Per-stage registers: skewed operands, partial sum, carry, valid.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] s_in   [STAGES];
  logic             c_in   [STAGES];
  logic             v_in   [STAGES];
  logic [SEG:0]     seg_sum [STAGES];
  logic [WIDTH-1:0] s_next [STAGES];
  logic             ovf_next;

  assign advance = !v_q[STAGES-1] || ready_i;
  assign ready_o = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // b is inverted and the carry-in flipped so subtraction reuses the adder.
      assign a_in[k] = a_i;
      assign b_in[k] = sub_i ? ~b_i : b_i;
      assign c_in[k] = cin_i ^ sub_i;
      assign s_in[k] = '0;
      assign v_in[k] = valid_i && advance;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    assign seg_sum[k] = {1'b0, a_in[k][k*SEG +: SEG]}
                      + {1'b0, b_in[k][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, c_in[k]};

    // Insert this stage's segment into the sum word, keeping lower segments.
    assign s_next[k] = (s_in[k] & ~(WIDTH'({SEG{1'b1}}) << (k*SEG)))
                     | (WIDTH'(seg_sum[k][SEG-1:0]) << (k*SEG));
  end

  assign ovf_next = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
                 && (seg_sum[STAGES-1][SEG-1] != a_in[STAGES-1][WIDTH-1]);

  // Pipeline registers: all stages shift together on advance, else hold.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_next[k];
        c_q[k] <= seg_sum[k][SEG];
        v_q[k] <= v_in[k];
      end
      ovf_q <= ovf_next;
    end
  end

  assign valid_o = v_q[STAGES-1];
  assign sum_o   = s_q[STAGES-1];
  assign cout_o  = c_q[STAGES-1];
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases on a 16x4 and 8x1
// instance, plus a randomized add/sub regression on 16-bit STAGES 1/2/4/8.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
    int ua, ub, sa, sb, u, s;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u = ua - ub - int'(cin);
      s = sa - sb - int'(cin);
      c = (u >= 0);
    end else begin
      u = ua + ub + int'(cin);
      s = sa + sb + int'(cin);
      c = (u > 65535);
    end
    o = (s > 32767) || (s < -32768);
    return {o, c, u[15:0]};
  endfunction

  // Main instance: WIDTH=16, STAGES=4.
  logic        m_valid = 1'b0, m_ready = 1'b1, m_cin = 1'b0, m_sub = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic        m_ready_o, m_valid_o, m_cout, m_ovf;
  logic [15:0] m_sum;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_main (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(m_valid), .ready_o(m_ready_o),
    .a_i(m_a), .b_i(m_b), .cin_i(m_cin), .sub_i(m_sub),
    .valid_o(m_valid_o), .ready_i(m_ready), .sum_o(m_sum), .cout_o(m_cout), .ovf_o(m_ovf)
  );

  // Degenerate instance: WIDTH=8, STAGES=1.
  logic       d_valid = 1'b0, d_ready = 1'b1;
  logic [7:0] d_a = '0, d_b = '0;
  logic       d_ready_o, d_valid_o, d_cout, d_ovf;
  logic [7:0] d_sum;

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_deg (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(d_valid), .ready_o(d_ready_o),
    .a_i(d_a), .b_i(d_b), .cin_i(1'b0), .sub_i(1'b0),
    .valid_o(d_valid_o), .ready_i(d_ready), .sum_o(d_sum), .cout_o(d_cout), .ovf_o(d_ovf)
  );

  // Random regression instances sharing one stimulus stream.
  logic        r_valid = 1'b0, r_ready = 1'b1, r_cin = 1'b0, r_sub = 1'b0;
  logic [15:0] r_a = '0, r_b = '0;
  logic [3:0]  r_ready_o, r_valid_o, r_cout, r_ovf;
  logic [15:0] r_sum [4];

  for (genvar g = 0; g < 4; g++) begin : g_rand
    pipelined_adder #(.WIDTH(16), .STAGES(1 << g)) u_rand (
      .clk_i(clk), .rst_n_i(rst_n), .valid_i(r_valid), .ready_o(r_ready_o[g]),
      .a_i(r_a), .b_i(r_b), .cin_i(r_cin), .sub_i(r_sub),
      .valid_o(r_valid_o[g]), .ready_i(r_ready), .sum_o(r_sum[g]),
      .cout_o(r_cout[g]), .ovf_o(r_ovf[g])
    );
  end

  logic [17:0] exp_mem [4][512];
  int          wr_ptr [4];
  int          rd_ptr [4];
  logic [15:0] bp_exp [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One item through the 16x4 instance, checking latency and result.
  task automatic send_wait(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub,
                           input logic [15:0] es, input logic ec, input logic eo);
    m_ready = 1'b1;
    m_valid = 1'b1; m_a = a; m_b = b; m_cin = cin; m_sub = sub;
    step();
    m_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_early"}, m_valid_o, 1'b0);
      step();
    end
    check({tag, "_valid"}, m_valid_o, 1'b1);
    check({tag, "_sum"}, m_sum, es);
    check({tag, "_cout"}, m_cout, ec);
    check({tag, "_ovf"}, m_ovf, eo);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc_now;
    int   acc, rcv;
    logic [15:0] sa [3];
    logic [15:0] sb [3];
    logic [15:0] se [3];

    // Reset state
    #12;
    check("rst_valid", m_valid_o, 1'b0);
    check("rst_sum", m_sum, 16'h0000);
    check("rst_cout", m_cout, 1'b0);
    check("rst_ovf", m_ovf, 1'b0);
    check("rst_ready", m_ready_o, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    send_wait("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_wait("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_wait("sub_borrow",16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // Back-to-back stream
    sa[0] = 16'h0FFF; sb[0] = 16'h0001; se[0] = 16'h1000;
    sa[1] = 16'h1234; sb[1] = 16'h4321; se[1] = 16'h5555;
    sa[2] = 16'h7FFF; sb[2] = 16'h0001; se[2] = 16'h8000;
    m_ready = 1'b1; m_sub = 1'b0; m_cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_valid = 1'b1; m_a = sa[i]; m_b = sb[i];
      step();
    end
    m_valid = 1'b0;
    step();
    for (int j = 0; j < 3; j++) begin
      check("stream_valid", m_valid_o, 1'b1);
      check("stream_sum", m_sum, se[j]);
      check("stream_ovf", m_ovf, (j == 2) ? 1'b1 : 1'b0);
      step();
    end
    check("stream_done", m_valid_o, 1'b0);

    // Backpressure: six items offered against a stalled consumer
    for (int i = 0; i < 6; i++) bp_exp[i] = ref_op(16'(i * 16'h1111), 16'h0101, 1'b0, 1'b0);
    acc = 0;
    m_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      m_valid = (acc < 6); m_a = 16'(acc * 16'h1111); m_b = 16'h0101;
      #1;
      acc_now = m_valid && m_ready_o;
      step();
      if (acc_now) acc++;
      if (cyc >= 3) begin
        check("bp_hold_valid", m_valid_o, 1'b1);
        check("bp_hold_sum", m_sum, bp_exp[0]);
      end
    end
    check("bp_accepted", acc, 4);
    check("bp_ready_low", m_ready_o, 1'b0);
    m_ready = 1'b1;
    rcv = 0;
    for (int cyc = 0; cyc < 30 && rcv < 6; cyc++) begin
      m_valid = (acc < 6); m_a = 16'(acc * 16'h1111); m_b = 16'h0101;
      #1;
      acc_now = m_valid && m_ready_o;
      if (m_valid_o && m_ready) begin
        check("bp_order", m_sum, bp_exp[rcv]);
        rcv++;
      end
      step();
      if (acc_now) acc++;
    end
    m_valid = 1'b0;
    check("bp_count", rcv, 6);
    for (int i = 0; i < 4; i++) begin
      check("bp_no_dup", m_valid_o, 1'b0);
      step();
    end

    // Reset mid-stream with three items in flight
    for (int i = 0; i < 3; i++) begin
      m_valid = 1'b1; m_a = 16'(16'h0100 + i); m_b = 16'h0002;
      step();
    end
    m_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", m_valid_o, 1'b0);
    check("mrst_sum", m_sum, 16'h0000);
    check("mrst_ovf", m_ovf, 1'b0);
    check("mrst_ready", m_ready_o, 1'b1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("mrst_no_stale", m_valid_o, 1'b0);
      step();
    end
    send_wait("after_rst", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0);

    // Degenerate single stage
    d_valid = 1'b1; d_a = 8'h7F; d_b = 8'h01;
    step();
    d_valid = 1'b0;
    check("deg_valid", d_valid_o, 1'b1);
    check("deg_sum", d_sum, 8'h80);
    check("deg_ovf", d_ovf, 1'b1);
    check("deg_cout", d_cout, 1'b0);
    step();
    check("deg_empty", d_valid_o, 1'b0);

    // Randomized regression with random backpressure, then drain
    for (int g = 0; g < 4; g++) begin
      wr_ptr[g] = 0;
      rd_ptr[g] = 0;
    end
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        r_valid = ($urandom_range(0, 3) != 0);
        r_a = 16'($urandom);
        r_b = 16'($urandom);
        if ($urandom_range(0, 7) == 0) r_a = 16'hFFFF;
        if ($urandom_range(0, 7) == 0) r_b = 16'h8000;
        r_cin = 1'($urandom_range(0, 1));
        r_sub = 1'($urandom_range(0, 1));
        r_ready = ($urandom_range(0, 3) != 0);
      end else begin
        r_valid = 1'b0;
        r_ready = 1'b1;
      end
      #1;
      for (int g = 0; g < 4; g++) begin
        if (r_valid_o[g] && r_ready) begin
          if (rd_ptr[g] == wr_ptr[g]) begin
            check($sformatf("rnd_s%0d_unexpected", 1 << g), 32'd1, 32'd0);
          end else begin
            check($sformatf("rnd_s%0d_result", 1 << g),
                  {14'd0, r_ovf[g], r_cout[g], r_sum[g]}, {14'd0, exp_mem[g][rd_ptr[g]]});
            rd_ptr[g]++;
          end
        end
        if (r_valid && r_ready_o[g]) begin
          exp_mem[g][wr_ptr[g]] = ref_op(r_a, r_b, r_cin, r_sub);
          wr_ptr[g]++;
        end
      end
      step();
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rnd_s%0d_drained", 1 << g), rd_ptr[g], wr_ptr[g]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
